// File: rtl/mem_fill_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_fill_pkg
//  Brief    : Shared types and constants for the line-fill arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_fill_pkg;

   // Backing memory is word addressed through a byte address.
   localparam int WORD_BYTES      = 4;
   localparam int DEF_BLOCK_WORDS = 8;
   localparam int LINE_BYTES      = DEF_BLOCK_WORDS * WORD_BYTES;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } fill_state_t;

   typedef enum logic {
      REQ_IC = 1'b0,
      REQ_DC = 1'b1
   } requester_t;

endpackage : mem_fill_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter2
//  Brief    : Two-way round-robin pick between icache and dcache requests.
//             Purely combinational; the caller owns the last-grant register.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
   import mem_fill_pkg::*;
(
   input  logic       req_ic_i,
   input  logic       req_dc_i,
   input  requester_t last_grant_i,
   output requester_t grant_o
);

   // Lone requester wins; on a tie the side not served last time wins.
   always_comb begin
      grant_o = REQ_IC;
      if (req_ic_i && req_dc_i) begin
         if (last_grant_i == REQ_IC) begin
            grant_o = REQ_DC;
         end else begin
            grant_o = REQ_IC;
         end
      end else if (req_dc_i) begin
         grant_o = REQ_DC;
      end
   end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/line_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : line_fill_arbiter
//  Brief    : Shares one word-wide memory read port between the icache and
//             dcache refill paths. One line fill at a time, one read
//             outstanding, each returned word streamed to the granted cache.
//  Options  : CRITICAL_WORD_FIRST_EN - start the burst at the missed word
//             and wrap within the line; otherwise always start at word 0.
//  Revision : 1.0 - initial release
// ============================================================================
module line_fill_arbiter
   import mem_fill_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int BLOCK_WORDS   = LINE_BYTES / WORD_BYTES,
   parameter int WORD_OFF_BITS = 3
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     ic_req,
   input  logic [ADDR_W-1:0]        ic_addr,
   input  logic                     dc_req,
   input  logic [ADDR_W-1:0]        dc_addr,
   output logic                     mem_rd,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic                     mem_rvalid,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic                     fill_we,
   output logic                     fill_sel,
   output logic [WORD_OFF_BITS-1:0] fill_word,
   output logic [DATA_W-1:0]        fill_data,
   output logic                     ic_done,
   output logic                     dc_done,
   output logic                     busy
);

   localparam int                     WORD_SHIFT = $clog2(WORD_BYTES);
   localparam logic [ADDR_W-1:0]      LINE_MASK  = ADDR_W'(BLOCK_WORDS * WORD_BYTES - 1);
   localparam logic [WORD_OFF_BITS-1:0] LAST_CNT = WORD_OFF_BITS'(BLOCK_WORDS - 1);
   localparam logic [WORD_OFF_BITS-1:0] ONE_W    = WORD_OFF_BITS'(1);

   fill_state_t              state_q, state_d;
   requester_t               grant_q, grant_d;
   requester_t               last_grant_q, last_grant_d;
   logic [ADDR_W-1:0]        base_q, base_d;
   logic [WORD_OFF_BITS-1:0] word_q, word_d;    // offset of the word in flight
   logic [WORD_OFF_BITS-1:0] count_q, count_d;  // words already delivered

   requester_t               w_grant;
   logic [ADDR_W-1:0]        w_sel_addr;
   logic [WORD_OFF_BITS-1:0] w_start;

   rr_arbiter2 u_rr_arbiter2 (
      .req_ic_i     (ic_req),
      .req_dc_i     (dc_req),
      .last_grant_i (last_grant_q),
      .grant_o      (w_grant)
   );

   assign w_sel_addr = (w_grant == REQ_DC) ? dc_addr : ic_addr;

`ifdef CRITICAL_WORD_FIRST_EN
   assign w_start = w_sel_addr[WORD_OFF_BITS+WORD_SHIFT-1:WORD_SHIFT];
`else
   assign w_start = '0;
`endif

   assign busy      = (state_q != IDLE);
   assign fill_sel  = grant_q;
   assign fill_word = word_q;
   assign fill_data = mem_rdata;

   // State and fill-context registers; reset kills any fill in progress.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         grant_q      <= REQ_IC;
         last_grant_q <= REQ_DC;
         base_q       <= '0;
         word_q       <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         base_q       <= base_d;
         word_q       <= word_d;
         count_q      <= count_d;
      end
   end

   // Next-state and output decode for the fill sequencer.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      base_d       = base_q;
      word_d       = word_q;
      count_d      = count_q;
      mem_rd       = 1'b0;
      mem_addr     = '0;
      fill_we      = 1'b0;
      ic_done      = 1'b0;
      dc_done      = 1'b0;

      case (state_q)
         IDLE: begin
            if (ic_req || dc_req) begin
               grant_d = w_grant;
               base_d  = w_sel_addr & ~LINE_MASK;
               word_d  = w_start;
               count_d = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            mem_rd   = 1'b1;
            mem_addr = base_q | (ADDR_W'(word_q) << WORD_SHIFT);
            state_d  = WAIT;
         end
         WAIT: begin
            // Return data is only meaningful while a read is outstanding.
            if (mem_rvalid) begin
               fill_we = 1'b1;
               word_d  = word_q + ONE_W;
               count_d = count_q + ONE_W;
               state_d = (count_q == LAST_CNT) ? DONE : ISSUE;
            end
         end
         DONE: begin
            ic_done      = (grant_q == REQ_IC);
            dc_done      = (grant_q == REQ_DC);
            last_grant_d = grant_q;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule : line_fill_arbiter
`default_nettype wire
